// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, default widths
// and the encoding of the read/not-write request line.
package mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  // rnw encodings
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory request/handshake signals. The shared data bus is a
// separate inout port on the responder because it is a resolved net.
interface mem_responder_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] mar;
  logic              rnw;
  logic              wmfc;
  logic              mfc;
  logic              busy;

  modport master (output mar, output rnw, output wmfc, input mfc, input busy);
  modport slave  (input mar, input rnw, input wmfc, output mfc, output busy);
endinterface

// File: rtl/mem_array.sv
// Storage for the responder: single port, synchronous write, registered
// synchronous read. Contents are never reset.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // commit writes and register read data on the enabling edge
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder on the shared CPU bus. Latches the request, waits
// LATENCY edges, then raises mfc; writes are committed and read data is
// registered on the edge that enters ACK. The bus is driven only in ACK of
// a read so the PC/MBR drivers never see contention.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  mem_responder_if.slave    bif,
  inout  wire  [DATA_W-1:0] bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  // WAIT is entered on the request edge, so LATENCY-1 further edges are
  // counted down before the edge that moves into ACK.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            r_state;
  state_e            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_latch;
  logic              w_enter_ack;
  logic [ADDR_W-1:0] r_addr;
  logic              r_dir;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic              w_we;
  logic              w_re;
  logic              w_drive;

  // next-state, counter and strobe decode
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_latch      = 1'b0;
    w_enter_ack  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bif.wmfc) begin
          w_latch      = 1'b1;
          w_next_state = ST_WAIT;
          w_next_cnt   = CNT_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bif.wmfc) begin
          // CPU withdrew the request: abort with no write and no mfc
          w_next_state = ST_IDLE;
          w_next_cnt   = {CNT_W{1'b0}};
        end else if (r_cnt == {CNT_W{1'b0}}) begin
          w_next_state = ST_ACK;
          w_enter_ack  = 1'b1;
        end else begin
          w_next_cnt   = r_cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (!bif.wmfc) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_ACK;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // state register, countdown and request latches
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_addr  <= {ADDR_W{1'b0}};
      r_dir   <= RD;
      r_wdata <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_latch) begin
        r_addr <= bif.mar;
        r_dir  <= bif.rnw;
        if (bif.rnw == WR) begin
          r_wdata <= bus;
        end
      end
    end
  end

  // Reset on the ACK-entry edge aborts the transaction, so gate the strobes.
  assign w_we = w_enter_ack && (r_dir == WR) && !reset;
  assign w_re = w_enter_ack && (r_dir == RD) && !reset;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clock   (clock),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign w_drive  = (r_state == ST_ACK) && (r_dir == RD);
  assign bus      = w_drive ? w_rdata : {DATA_W{1'bz}};
  assign bif.mfc  = (r_state == ST_ACK);
  assign bif.busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a LATENCY=2 and a LATENCY=1 instance share the
// same request stimulus, each with its own bus and its own transaction-level
// model (timestamps and a storage array).
module tb_mem_responder;
  import mem_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [7:0] s_mar;
  logic       s_rnw;
  logic       s_wmfc;
  logic [7:0] drv_val;

  mem_responder_if #(.ADDR_W(8)) bif0 ();
  mem_responder_if #(.ADDR_W(8)) bif1 ();
  assign bif0.mar = s_mar;  assign bif0.rnw = s_rnw;  assign bif0.wmfc = s_wmfc;
  assign bif1.mar = s_mar;  assign bif1.rnw = s_rnw;  assign bif1.wmfc = s_wmfc;

  wire [7:0] bus0;
  wire [7:0] bus1;

  // model state, one slot per DUT
  int         lat [2] = '{2, 1};
  bit         m_act [2];
  bit         m_ack [2];
  bit         m_dir [2];
  int         m_start [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wd [2];
  logic [7:0] m_rd [2];
  bit         m_rd_ok [2];
  logic [7:0] mm [2][256];
  bit         mv [2][256];
  int         edge_no = 0;
  bit         chk_en = 1'b0;

  // the bench plays the other bus drivers whenever the responder must not drive
  assign bus0 = (m_ack[0] && m_dir[0]) ? 8'hzz : drv_val;
  assign bus1 = (m_ack[1] && m_dir[1]) ? 8'hzz : drv_val;

  mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(2)) dut0 (
    .clock (clock), .reset (reset), .bif (bif0.slave), .bus (bus0));
  mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(1)) dut1 (
    .clock (clock), .reset (reset), .bif (bif1.slave), .bus (bus1));

  logic       d_mfc [2];
  logic       d_busy [2];
  logic [7:0] d_bus [2];
  assign d_mfc[0] = bif0.mfc;  assign d_busy[0] = bif0.busy;  assign d_bus[0] = bus0;
  assign d_mfc[1] = bif1.mfc;  assign d_busy[1] = bif1.busy;  assign d_bus[1] = bus1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transaction-level model: request accepted at edge E, acknowledged at E+latency
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k] <= 1'b0;
        m_ack[k] <= 1'b0;
      end else if (!m_act[k]) begin
        if (s_wmfc) begin
          m_act[k]   <= 1'b1;
          m_start[k] <= edge_no;
          m_dir[k]   <= s_rnw;
          m_addr[k]  <= s_mar;
          if (s_rnw == WR) m_wd[k] <= drv_val;
        end
      end else if (!s_wmfc) begin
        m_act[k] <= 1'b0;
        m_ack[k] <= 1'b0;
      end else if (!m_ack[k] && (edge_no - m_start[k] == lat[k])) begin
        m_ack[k] <= 1'b1;
        if (m_dir[k] == WR) begin
          mm[k][m_addr[k]] <= m_wd[k];
          mv[k][m_addr[k]] <= 1'b1;
        end else begin
          m_rd[k]    <= mm[k][m_addr[k]];
          m_rd_ok[k] <= mv[k][m_addr[k]];
        end
      end
    end
    edge_no <= edge_no + 1;
    if (reset) chk_en <= 1'b1;
  end

  // every-cycle comparison of both DUTs against the model
  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("mfc%0d", k), {7'b0, d_mfc[k]}, {7'b0, m_ack[k]});
        check($sformatf("busy%0d", k), {7'b0, d_busy[k]}, {7'b0, m_act[k]});
        if (m_ack[k] && m_dir[k]) begin
          if (m_rd_ok[k]) check($sformatf("rdbus%0d", k), d_bus[k], m_rd[k]);
        end else begin
          check($sformatf("relbus%0d", k), d_bus[k], drv_val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // full handshake; optional change of mar/rnw/bus one cycle after the request
  task automatic txn(input logic rnw, input logic [7:0] addr, input logic [7:0] wd,
                     input bit disturb, output int lat0, output int lat1,
                     output logic [7:0] rd0, output logic [7:0] rd1);
    int n;
    s_mar = addr;  s_rnw = rnw;  drv_val = wd;  s_wmfc = 1'b1;
    n = 0;  lat0 = -1;  lat1 = -1;
    while (!bif0.mfc && n < 20) begin
      tick();
      n++;
      if (disturb && n == 1) begin
        s_mar = addr + 8'd1;  s_rnw = WR;  drv_val = 8'hFF;
      end
      if (bif1.mfc && lat1 < 0) lat1 = n - 1;
    end
    if (!bif0.mfc) check("mfc_timeout", 8'd0, 8'd1);
    lat0 = n - 1;
    rd0 = bus0;  rd1 = bus1;
    s_wmfc = 1'b0;
    tick();
    check("mfc_drop", {7'b0, bif0.mfc}, 8'd0);
    drv_val = 8'($urandom);
  endtask

  int l0, l1;
  logic [7:0] r0, r1;

  initial begin
    reset = 1'b1;  s_wmfc = 1'b1;  s_mar = 8'h33;  s_rnw = WR;  drv_val = 8'h5C;
    // 1: reset for two edges with the request held high
    tick();  tick();
    check("rst_mfc0", {7'b0, bif0.mfc}, 8'd0);
    check("rst_busy0", {7'b0, bif0.busy}, 8'd0);
    check("rst_mfc1", {7'b0, bif1.mfc}, 8'd0);
    check("rst_bus0", bus0, 8'h5C);
    s_wmfc = 1'b0;  reset = 1'b0;
    tick();

    // 2: write then read, with latency pinned
    txn(WR, 8'h01, 8'hA5, 1'b0, l0, l1, r0, r1);
    check("lat_l2", 8'(l0), 8'd2);
    check("lat_l1", 8'(l1), 8'd1);
    txn(WR, 8'h02, 8'h77, 1'b0, l0, l1, r0, r1);
    txn(RD, 8'h01, 8'h00, 1'b0, l0, l1, r0, r1);
    check("rd01_d0", r0, 8'hA5);
    check("rd01_d1", r1, 8'hA5);

    // 3: mar/rnw/bus change after the latch edge
    txn(RD, 8'h01, 8'h00, 1'b1, l0, l1, r0, r1);
    check("latch_d0", r0, 8'hA5);
    txn(RD, 8'h02, 8'h00, 1'b0, l0, l1, r0, r1);
    check("mem02_kept", r0, 8'h77);

    // 4: abort in WAIT (LATENCY=2 only; LATENCY=1 has acked by then)
    txn(WR, 8'h10, 8'h11, 1'b0, l0, l1, r0, r1);
    s_mar = 8'h10;  s_rnw = WR;  drv_val = 8'h3C;  s_wmfc = 1'b1;
    tick();
    check("abort_e0", {7'b0, bif0.mfc}, 8'd0);
    tick();
    check("abort_e1", {7'b0, bif0.mfc}, 8'd0);
    s_wmfc = 1'b0;
    tick();
    check("abort_idle", {7'b0, bif0.busy}, 8'd0);
    check("abort_mfc", {7'b0, bif0.mfc}, 8'd0);
    tick();
    txn(RD, 8'h10, 8'h00, 1'b0, l0, l1, r0, r1);
    check("abort_rd_d0", r0, 8'h11);
    check("abort_rd_d1", r1, 8'h3C);

    // 5: reset while a read is acknowledged
    s_mar = 8'h01;  s_rnw = RD;  s_wmfc = 1'b1;
    tick();  tick();  tick();
    check("pre_rst_mfc", {7'b0, bif0.mfc}, 8'd1);
    reset = 1'b1;
    tick();
    check("midrst_mfc", {7'b0, bif0.mfc}, 8'd0);
    check("midrst_busy", {7'b0, bif0.busy}, 8'd0);
    check("midrst_bus", bus0, drv_val);
    reset = 1'b0;  s_wmfc = 1'b0;
    tick();
    txn(RD, 8'h01, 8'h00, 1'b0, l0, l1, r0, r1);
    check("post_rst_rd", r0, 8'hA5);

    // 6: address extremes
    txn(WR, 8'hFF, 8'h5A, 1'b0, l0, l1, r0, r1);
    txn(WR, 8'h00, 8'hC3, 1'b0, l0, l1, r0, r1);
    txn(RD, 8'hFF, 8'h00, 1'b0, l0, l1, r0, r1);
    check("rdFF_d0", r0, 8'h5A);
    check("rdFF_d1", r1, 8'h5A);
    txn(RD, 8'h00, 8'h00, 1'b0, l0, l1, r0, r1);
    check("rd00_d0", r0, 8'hC3);
    check("rd00_d1", r1, 8'hC3);
    check("lat_l1_again", 8'(l1), 8'd1);

    // random requests with arbitrary hold/drop lengths and noisy inputs
    for (int i = 0; i < 300; i++) begin
      s_mar   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      s_rnw   = 1'($urandom);
      drv_val = 8'($urandom);
      s_wmfc  = 1'b1;
      for (int h = $urandom_range(1, 5); h > 0; h--) begin
        tick();
        if ($urandom_range(0, 1) == 1) begin
          s_mar = 8'($urandom);  s_rnw = 1'($urandom);  drv_val = 8'($urandom);
        end
      end
      s_wmfc = 1'b0;
      for (int d = $urandom_range(1, 2); d > 0; d--) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
